// File: rtl/vec_operand_sequencer_pkg.sv
// Shared constants for the vector operand sequencer: funct3 operand formats,
// SEW encodings, FSM states and the SEW broadcast helper.
package vec_operand_sequencer_pkg;

  localparam logic [2:0] OPIVV = 3'b000;
  localparam logic [2:0] OPIVX = 3'b100;
  localparam logic [2:0] OPIVI = 3'b011;

  typedef enum logic [1:0] {
    SEW8  = 2'd0,
    SEW16 = 2'd1,
    SEW32 = 2'd2,
    SEW64 = 2'd3
  } sew_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Replicates the low SEW bits of a scalar across a full 64-bit beat.
  function automatic logic [63:0] sew_broadcast(input logic [63:0] i_val, input sew_e i_sew);
    logic [63:0] w_res;
    case (i_sew)
      SEW8:    w_res = {8{i_val[7:0]}};
      SEW16:   w_res = {4{i_val[15:0]}};
      SEW32:   w_res = {2{i_val[31:0]}};
      default: w_res = i_val;
    endcase
    return w_res;
  endfunction

endpackage

// File: rtl/vec_operand_sequencer_skid_buf.sv
// vopseq_skid_buf: 2-entry FIFO of {data, last} beats with push, pop, count
// and head outputs; a push while full is accepted only alongside a pop.
module vopseq_skid_buf (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_push,
  input  logic [63:0] i_push_data,
  input  logic        i_push_last,
  input  logic        i_pop,
  output logic [1:0]  o_count,
  output logic        o_head_valid,
  output logic [63:0] o_head_data,
  output logic        o_head_last
);

  logic [63:0] r_data [2];
  logic [1:0]  r_last;
  logic        r_wr_ptr;
  logic        r_rd_ptr;
  logic [1:0]  r_count;
  logic        w_pop;
  logic        w_push;

  assign w_pop  = i_pop && (r_count != 2'd0);
  assign w_push = i_push && ((r_count != 2'd2) || w_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data[0] <= '0;
      r_data[1] <= '0;
      r_last    <= '0;
      r_wr_ptr  <= 1'b0;
      r_rd_ptr  <= 1'b0;
      r_count   <= 2'd0;
    end else begin
      if (w_push) begin
        r_data[r_wr_ptr] <= i_push_data;
        r_last[r_wr_ptr] <= i_push_last;
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 2'd1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 2'd1;
      end
    end
  end

  assign o_count      = r_count;
  assign o_head_valid = (r_count != 2'd0);
  assign o_head_data  = r_data[r_rd_ptr];
  assign o_head_last  = r_last[r_rd_ptr];

endmodule

// File: rtl/vec_operand_sequencer.sv
// Streams operand A of a vector instruction (VRF, scalar or immediate source)
// as 64-bit beats. Optional VOPSEQ_PERF_CNT_EN adds beat/stall counters.
module vec_operand_sequencer
  import vec_operand_sequencer_pkg::*;
#(
  parameter  int VLEN  = 512,
  parameter  int VL_W  = 10,
  localparam int IDX_W = $clog2(VLEN / 64)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_issue_valid,
  output logic             o_issue_ready,
  input  logic [2:0]       i_funct3,
  input  logic [4:0]       i_vs1,
  input  logic [1:0]       i_vsew,
  input  logic [VL_W-1:0]  i_vl,
  input  logic [63:0]      i_scalar_in_64,
  input  logic [63:0]      i_simm64,
  output logic             o_vrf_rd_en,
  output logic [4+IDX_W:0] o_vrf_rd_addr,
  input  logic [63:0]      i_vrf_rd_data,
  output logic             o_op_valid,
  input  logic             i_op_ready,
  output logic [63:0]      o_op_data,
  output logic             o_op_last,
  output logic             o_busy,
  output logic             o_err_illegal
`ifdef VOPSEQ_PERF_CNT_EN
  ,
  output logic [31:0]      o_perf_beats,
  output logic [31:0]      o_perf_stall
`endif
);

  localparam int NBEATS_MAX = VLEN / 64;
  localparam int CNT_W      = IDX_W + 1;
  localparam int BW         = VL_W + 7;

  state_e           r_state;
  state_e           w_state_nxt;
  logic             r_is_vv;
  logic [4:0]       r_vs1;
  logic [CNT_W-1:0] r_nbeats;
  logic [CNT_W-1:0] r_issue_cnt;
  logic [63:0]      r_bcast;
  logic             r_rd_pending;
  logic             r_rd_last;
  logic             r_err;

  logic             w_accept;
  logic             w_legal;
  logic [BW-1:0]    w_bits;
  logic [BW-1:0]    w_beats_raw;
  logic [CNT_W-1:0] w_nbeats;
  logic             w_issue;
  logic             w_issue_last;
  logic [2:0]       w_occ;
  logic             w_pop;
  logic             w_push;
  logic [63:0]      w_push_data;
  logic             w_push_last;
  logic [1:0]       w_count;
  logic             w_head_valid;
  logic             w_head_last;
  logic [63:0]      w_head_data;

  assign w_accept    = (r_state == IDLE) && i_issue_valid;
  assign w_legal     = (i_funct3 == OPIVV) || (i_funct3 == OPIVX) || (i_funct3 == OPIVI);
  assign w_bits      = BW'(i_vl) << (3'd3 + 3'(i_vsew));
  assign w_beats_raw = (w_bits + BW'(63)) >> 6;
  assign w_nbeats    = (w_beats_raw > BW'(NBEATS_MAX)) ? CNT_W'(NBEATS_MAX)
                                                       : w_beats_raw[CNT_W-1:0];

  // Occupancy counts the in-flight read and frees the slot being popped this cycle.
  assign w_pop        = w_head_valid && i_op_ready;
  assign w_occ        = {1'b0, w_count} + {2'b00, r_rd_pending} - {2'b00, w_pop};
  assign w_issue_last = (r_issue_cnt == (r_nbeats - CNT_W'(1)));

  always_comb begin
    w_state_nxt   = r_state;
    o_issue_ready = 1'b0;
    o_busy        = 1'b0;
    w_issue       = 1'b0;
    case (r_state)
      IDLE: begin
        o_issue_ready = 1'b1;
        if (w_accept && w_legal && (w_nbeats != '0)) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        o_busy  = 1'b1;
        w_issue = (r_issue_cnt < r_nbeats) && (w_occ < 3'd2);
        if (w_pop && w_head_last) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign o_vrf_rd_en   = w_issue && r_is_vv;
  assign o_vrf_rd_addr = {r_vs1, r_issue_cnt[IDX_W-1:0]};

  assign w_push      = r_rd_pending || (w_issue && !r_is_vv);
  assign w_push_data = r_rd_pending ? i_vrf_rd_data : r_bcast;
  assign w_push_last = r_rd_pending ? r_rd_last : w_issue_last;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_is_vv      <= 1'b0;
      r_vs1        <= '0;
      r_nbeats     <= '0;
      r_issue_cnt  <= '0;
      r_bcast      <= '0;
      r_rd_pending <= 1'b0;
      r_rd_last    <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_rd_pending <= o_vrf_rd_en;
      r_rd_last    <= w_issue_last;
      r_err        <= w_accept && !w_legal;
      if (w_accept) begin
        r_is_vv     <= (i_funct3 == OPIVV);
        r_vs1       <= i_vs1;
        r_nbeats    <= w_nbeats;
        r_issue_cnt <= '0;
        r_bcast     <= sew_broadcast((i_funct3 == OPIVX) ? i_scalar_in_64 : i_simm64,
                                     sew_e'(i_vsew));
      end else if (w_issue) begin
        r_issue_cnt <= r_issue_cnt + CNT_W'(1);
      end
    end
  end

  vopseq_skid_buf u_skid_buf (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_push       (w_push),
    .i_push_data  (w_push_data),
    .i_push_last  (w_push_last),
    .i_pop        (w_pop),
    .o_count      (w_count),
    .o_head_valid (w_head_valid),
    .o_head_data  (w_head_data),
    .o_head_last  (w_head_last)
  );

  assign o_op_valid    = w_head_valid;
  assign o_op_data     = w_head_data;
  assign o_op_last     = w_head_last;
  assign o_err_illegal = r_err;

`ifdef VOPSEQ_PERF_CNT_EN
  logic [31:0] r_perf_beats;
  logic [31:0] r_perf_stall;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_perf_beats <= '0;
      r_perf_stall <= '0;
    end else begin
      r_perf_beats <= r_perf_beats + 32'(w_pop);
      r_perf_stall <= r_perf_stall + 32'(w_head_valid && !i_op_ready);
    end
  end

  assign o_perf_beats = r_perf_beats;
  assign o_perf_stall = r_perf_stall;
`endif

endmodule

// File: tb/tb_vec_operand_sequencer.sv
// Scoreboard bench for vec_operand_sequencer: a driver queues expected beats
// and VRF addresses, a negedge monitor pops and compares them.
module tb_vec_operand_sequencer;

  localparam int VLEN   = 512;
  localparam int VL_W   = 10;
  localparam int NB_MAX = VLEN / 64;
  localparam logic [2:0] F_VV = 3'b000;
  localparam logic [2:0] F_VX = 3'b100;
  localparam logic [2:0] F_VI = 3'b011;

  typedef struct {
    logic [63:0] data;
    logic        last;
    logic        isVv;
    logic        first;
  } beat_t;

  logic            clk;
  logic            rstN;
  logic            issueValid;
  logic            issueReady;
  logic [2:0]      funct3;
  logic [4:0]      vs1;
  logic [1:0]      vsew;
  logic [VL_W-1:0] vl;
  logic [63:0]     scalarIn;
  logic [63:0]     simm;
  logic            vrfRdEn;
  logic [7:0]      vrfRdAddr;
  logic [63:0]     vrfRdData;
  logic            opValid;
  logic            opReady;
  logic [63:0]     opData;
  logic            opLast;
  logic            busy;
  logic            errIllegal;
`ifdef VOPSEQ_PERF_CNT_EN
  logic [31:0]     perfBeats;
  logic [31:0]     perfStall;
`endif

  int          assertCnt = 0;
  int          failCnt = 0;
  int          cyc = 0;
  beat_t       expBeats[$];
  int          expAddr[$];
  beat_t       monBeat;
  logic [63:0] vrf [256];
  int          readyMode = 0;
  int          latExp = 0;
  int          accCyc = 0;
  bit          latArmed = 0;
  int          errCyc = -10;
  int          vvReads = 0;
  int          vvBeats = 0;
  int          beatsAcc = 0;
  bit          prevStall = 0;
  logic [63:0] prevData = '0;
  logic        prevLast = 1'b0;
  int          prevBeatCyc = 0;
  bit          idleChk = 0;
  bit          vrfPend = 0;
  logic [7:0]  vrfPendAddr = '0;

  vec_operand_sequencer #(.VLEN(VLEN), .VL_W(VL_W)) dut (
    .i_clk          (clk),
    .i_rst_n        (rstN),
    .i_issue_valid  (issueValid),
    .o_issue_ready  (issueReady),
    .i_funct3       (funct3),
    .i_vs1          (vs1),
    .i_vsew         (vsew),
    .i_vl           (vl),
    .i_scalar_in_64 (scalarIn),
    .i_simm64       (simm),
    .o_vrf_rd_en    (vrfRdEn),
    .o_vrf_rd_addr  (vrfRdAddr),
    .i_vrf_rd_data  (vrfRdData),
    .o_op_valid     (opValid),
    .i_op_ready     (opReady),
    .o_op_data      (opData),
    .o_op_last      (opLast),
    .o_busy         (busy),
    .o_err_illegal  (errIllegal)
`ifdef VOPSEQ_PERF_CNT_EN
    , .o_perf_beats (perfBeats),
    .o_perf_stall   (perfStall)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Reference model: beat count and SEW broadcast straight from the arithmetic rules.
  function automatic int nbeatsOf(input logic [1:0] sew, input logic [VL_W-1:0] n);
    int bits;
    int nb;
    bits = int'(n) * (8 << sew);
    nb   = (bits + 63) / 64;
    if (nb > NB_MAX) nb = NB_MAX;
    return nb;
  endfunction

  function automatic logic [63:0] bcastOf(input logic [63:0] val, input logic [1:0] sew);
    int w;
    logic [63:0] low;
    logic [63:0] res;
    w   = 8 << sew;
    low = (w == 64) ? val : (val & ((64'd1 << w) - 64'd1));
    res = '0;
    for (int i = 0; i < 64; i += w) res = res | (low << i);
    return res;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    assertCnt++;
    if (act !== exp) begin
      failCnt++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // VRF model: data for a read appears just after the following rising edge.
  initial begin
    vrfRdData = '0;
    forever begin
      @(posedge clk);
      #1;
      vrfRdData = vrfPend ? vrf[vrfPendAddr] : {$urandom, $urandom};
    end
  end

  // op_ready patterns: 0 = always ready, 1 = 1,0,0 repeating, 2 = random.
  initial begin
    int ph;
    ph = 0;
    opReady = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (readyMode)
        0:       opReady = 1'b1;
        1:       opReady = (ph % 3 == 0);
        default: opReady = 1'($urandom_range(0, 1));
      endcase
      ph++;
    end
  end

  // Monitor: pops the scoreboard on every handshake and checks protocol rules.
  always @(negedge clk) begin
    if (rstN) begin
      if (errIllegal || (cyc == errCyc)) begin
        checkOutput("err_illegal", 64'(errIllegal), 64'(cyc == errCyc));
      end
      if (idleChk) begin
        checkOutput("idle_after_last", 64'(issueReady && !busy), 64'd1);
        idleChk = 0;
      end
      if (prevStall) begin
        checkOutput("stall_valid", 64'(opValid), 64'd1);
        checkOutput("stall_data", opData, prevData);
        checkOutput("stall_last", 64'(opLast), 64'(prevLast));
      end
      if (opValid && latArmed) begin
        checkOutput("first_latency", 64'(cyc - accCyc), 64'(latExp));
        latArmed = 0;
      end
      if (opValid && opReady) begin
        if (expBeats.size() == 0) begin
          checkOutput("unexpected_beat", 64'(opValid), 64'd0);
        end else begin
          monBeat = expBeats.pop_front();
          checkOutput("beat_data", opData, monBeat.data);
          checkOutput("beat_last", 64'(opLast), 64'(monBeat.last));
          if (monBeat.isVv) vvBeats++;
          if ((readyMode == 0) && !monBeat.first) begin
            checkOutput("throughput_gap", 64'(cyc - prevBeatCyc), 64'd1);
          end
          prevBeatCyc = cyc;
          if (monBeat.last) idleChk = 1;
        end
        beatsAcc++;
      end
      if (vrfRdEn) begin
        if (expAddr.size() == 0) begin
          checkOutput("unexpected_read", 64'(vrfRdEn), 64'd0);
        end else begin
          checkOutput("rd_addr", 64'(vrfRdAddr), 64'(expAddr.pop_front()));
        end
        checkOutput("outstanding_le_2", 64'((vvReads - vvBeats + 1) <= 2), 64'd1);
        vvReads++;
      end
      vrfPend     = vrfRdEn;
      vrfPendAddr = vrfRdAddr;
      prevStall   = opValid && !opReady;
      prevData    = opData;
      prevLast    = opLast;
    end
  end

  task automatic applyStimulus(input logic [2:0] f3, input logic [4:0] v1, input logic [1:0] sew,
                               input logic [VL_W-1:0] n, input logic [63:0] sc, input logic [63:0] im);
    int    waitN;
    int    nb;
    bit    legal;
    bit    isVv;
    logic [63:0] bc;
    beat_t b;
    waitN = 0;
    @(negedge clk);
    while (!issueReady && waitN < 4000) begin
      @(negedge clk);
      waitN++;
    end
    if (!issueReady) begin
      assertCnt++;
      failCnt++;
      $display("[TB] FAIL issue_wait: issue_ready got 0, expected 1");
    end
    legal = (f3 == F_VV) || (f3 == F_VX) || (f3 == F_VI);
    isVv  = (f3 == F_VV);
    nb    = nbeatsOf(sew, n);
    funct3 = f3; vs1 = v1; vsew = sew; vl = n; scalarIn = sc; simm = im;
    issueValid = 1'b1;
    accCyc = cyc + 1;
    if (!legal) begin
      errCyc = accCyc;
    end else if (nb > 0) begin
      bc = bcastOf((f3 == F_VX) ? sc : im, sew);
      for (int k = 0; k < nb; k++) begin
        b.data  = isVv ? vrf[int'(v1) * NB_MAX + k] : bc;
        b.last  = (k == nb - 1);
        b.isVv  = isVv;
        b.first = (k == 0);
        expBeats.push_back(b);
        if (isVv) expAddr.push_back(int'(v1) * NB_MAX + k);
      end
      latExp   = isVv ? 2 : 1;
      latArmed = 1;
    end
    @(posedge clk);
    #1;
    issueValid = 1'b0;
    @(negedge clk);
    #1;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while ((!issueReady || expBeats.size() != 0) && n < 4000) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!issueReady || expBeats.size() != 0) begin
      assertCnt++;
      failCnt++;
      $display("[TB] FAIL drain_timeout: %0d beats outstanding, expected 0", expBeats.size());
      expBeats.delete();
      expAddr.delete();
    end
  endtask

  initial begin
    logic [2:0]      f3r;
    logic [VL_W-1:0] vlr;
    int              sel;
    int              base;
    int              n;

    for (int i = 0; i < 256; i++) vrf[i] = {$urandom, $urandom};
    rstN = 1'b0; issueValid = 1'b0; funct3 = '0; vs1 = '0; vsew = '0; vl = '0;
    scalarIn = '0; simm = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_issue_ready", 64'(issueReady), 64'd1);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_op_valid", 64'(opValid), 64'd0);
    checkOutput("rst_op_last", 64'(opLast), 64'd0);
    checkOutput("rst_op_data", opData, 64'd0);
    checkOutput("rst_rd_en", 64'(vrfRdEn), 64'd0);
    checkOutput("rst_err", 64'(errIllegal), 64'd0);
    #2 rstN = 1'b1;

    $display("[TB] directed: OPIVV / OPIVX / OPIVI");
    readyMode = 0;
    applyStimulus(F_VV, 5'd5, 2'd3, 10'd8, 64'd0, 64'd0);
    waitIdle();
    applyStimulus(F_VX, 5'd1, 2'd0, 10'd20, 64'h1234_5678_9ABC_00A5, 64'd0);
    waitIdle();
    applyStimulus(F_VI, 5'd2, 2'd2, 10'd1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFD);
    waitIdle();

    $display("[TB] directed: back-pressure 1,0,0");
    readyMode = 1;
    applyStimulus(F_VV, 5'd9, 2'd3, 10'd8, 64'd0, 64'd0);
    waitIdle();

    $display("[TB] directed: illegal funct3, vl=0, saturation");
    readyMode = 0;
    applyStimulus(3'b111, 5'd3, 2'd0, 10'd4, 64'd7, 64'd0);
    checkOutput("illegal_issue_ready", 64'(issueReady), 64'd1);
    applyStimulus(F_VX, 5'd3, 2'd1, 10'd0, 64'd7, 64'd0);
    checkOutput("vl0_issue_ready", 64'(issueReady), 64'd1);
    checkOutput("vl0_busy", 64'(busy), 64'd0);
    applyStimulus(F_VV, 5'd31, 2'd3, 10'd100, 64'd0, 64'd0);
    waitIdle();
    applyStimulus(F_VX, 5'd0, 2'd0, 10'd65, 64'hFFFF_FFFF_FFFF_FF3C, 64'd0);
    waitIdle();

    $display("[TB] directed: reset mid-instruction");
    base = beatsAcc;
    applyStimulus(F_VV, 5'd12, 2'd3, 10'd8, 64'd0, 64'd0);
    n = 0;
    while (beatsAcc < base + 3 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    #2 rstN = 1'b0;
    #1;
    checkOutput("midrst_op_valid", 64'(opValid), 64'd0);
    checkOutput("midrst_issue_ready", 64'(issueReady), 64'd1);
    checkOutput("midrst_busy", 64'(busy), 64'd0);
    checkOutput("midrst_rd_en", 64'(vrfRdEn), 64'd0);
    expBeats.delete(); expAddr.delete();
    latArmed = 0; prevStall = 0; idleChk = 0; vrfPend = 0; vvReads = 0; vvBeats = 0;
    @(negedge clk);
    #2 rstN = 1'b1;
    applyStimulus(F_VV, 5'd12, 2'd3, 10'd8, 64'd0, 64'd0);
    waitIdle();

    $display("[TB] random instructions");
    for (int i = 0; i < 40; i++) begin
      waitIdle();
      readyMode = $urandom_range(0, 2);
      sel = $urandom_range(0, 9);
      f3r = (sel < 4) ? F_VV : (sel < 7) ? F_VX : (sel < 9) ? F_VI : 3'b111;
      case ($urandom_range(0, 3))
        0:       vlr = (f3r == 3'b111) ? 10'd1 : 10'd0;
        1:       vlr = 10'($urandom_range(1, 16));
        2:       vlr = 10'($urandom_range(1, 128));
        default: vlr = 10'($urandom_range(1, 1023));
      endcase
      applyStimulus(f3r, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), vlr,
                    {$urandom, $urandom}, {$urandom, $urandom});
    end
    waitIdle();
    repeat (4) @(negedge clk);
    checkOutput("final_beats_left", 64'(expBeats.size()), 64'd0);
    checkOutput("final_addrs_left", 64'(expAddr.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
    $finish;
  end

endmodule
